// File: rtl/systolic_pkg.sv
// Shared types and default sizing for the systolic array result path.
package systolic_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_ROWS  = 4;

  typedef logic signed [DEF_WIDTH-1:0] psum_t;
  typedef psum_t [DEF_ROWS-1:0]        psum_vec_t;
endpackage

// File: rtl/systolic_result_fifo.sv
// Synchronous FIFO for aligned result vectors; pointers carry an extra wrap bit.
// Handshake: push is accepted when not full or when a pop happens the same
// cycle; pop is accepted only when not empty. rdata is the head, valid when !empty.
module systolic_result_fifo
  import systolic_pkg::*;
#(
  parameter int W     = DEF_ROWS * DEF_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/systolic_result_drain.sv
// Right-edge partial-sum capture: de-skews array rows into one vector, buffers
// it, and flags drops/misalignment since the array cannot be stalled.
module systolic_result_drain
  import systolic_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ROWS  = DEF_ROWS,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ROWS*WIDTH-1:0] row_psum,
  input  logic [ROWS-1:0]       row_valid,
  output logic [ROWS*WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overflow,
  output logic                  err_misalign,
  input  logic                  clr_err,
  output logic [15:0]           result_count
);
  logic [WIDTH-1:0]      al_d [ROWS];
  logic                  al_v [ROWS];
  logic [ROWS*WIDTH-1:0] aligned;
  logic [ROWS-1:0]       av;
  logic                  push_req;
  logic                  misalign;
  logic                  pop;
  logic                  full;
  logic                  empty;

  // Row r waits ROWS-1-r cycles so every row lines up with the last one.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    if (r == ROWS - 1) begin : g_direct
      assign al_d[r] = row_psum[r*WIDTH +: WIDTH];
      assign al_v[r] = row_valid[r];
    end else begin : g_delay
      localparam int D = ROWS - 1 - r;
      logic [WIDTH-1:0] dl_d [D];
      logic             dl_v [D];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < D; i++) begin
            dl_d[i] <= '0;
            dl_v[i] <= 1'b0;
          end
        end else begin
          dl_d[0] <= row_psum[r*WIDTH +: WIDTH];
          dl_v[0] <= row_valid[r];
          for (int i = 1; i < D; i++) begin
            dl_d[i] <= dl_d[i-1];
            dl_v[i] <= dl_v[i-1];
          end
        end
      end

      assign al_d[r] = dl_d[D-1];
      assign al_v[r] = dl_v[D-1];
    end
  end

  always_comb begin
    aligned = '0;
    av      = '0;
    for (int r = 0; r < ROWS; r++) begin
      aligned[r*WIDTH +: WIDTH] = al_d[r];
      av[r]                     = al_v[r];
    end
  end

  assign push_req  = &av;
  assign misalign  = (|av) & ~(&av);
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;

  systolic_result_fifo #(
    .W     (ROWS * WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop),
    .wdata (aligned),
    .rdata (out_data),
    .full  (full),
    .empty (empty)
  );

  // Set events take priority over clr_err so a same-cycle error is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow     <= 1'b0;
      err_misalign <= 1'b0;
      result_count <= '0;
    end else begin
      if (push_req & full & ~pop) overflow <= 1'b1;
      else if (clr_err)           overflow <= 1'b0;
      if (misalign)               err_misalign <= 1'b1;
      else if (clr_err)           err_misalign <= 1'b0;
      if (pop) result_count <= result_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_systolic_result_drain.sv
// Randomized and directed bench for systolic_result_drain with a queue-based
// reference model and a decoupled output monitor.
module tb_systolic_result_drain;
  localparam int W = 16;
  localparam int R = 4;
  localparam int D = 4;
  localparam int VW = R * W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [VW-1:0] row_psum = '0;
  logic [R-1:0]  row_valid = '0;
  logic          out_ready = 1'b0;
  logic          clr_err = 1'b0;
  logic [VW-1:0] out_data;
  logic          out_valid;
  logic          overflow;
  logic          err_misalign;
  logic [15:0]   result_count;

  systolic_result_drain #(.WIDTH(W), .ROWS(R), .DEPTH(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .row_psum     (row_psum),
    .row_valid    (row_valid),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .overflow     (overflow),
    .err_misalign (err_misalign),
    .clr_err      (clr_err),
    .result_count (result_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] hd_q[$];
  logic [R-1:0]  hv_q[$];
  int            occ = 0;
  logic          exp_ovf = 1'b0;
  logic          exp_mis = 1'b0;
  logic [15:0]   exp_cnt = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete(); hd_q.delete(); hv_q.delete();
      occ = 0; exp_ovf = 1'b0; exp_mis = 1'b0; exp_cnt = '0;
    end else begin
      logic [R-1:0]  av;
      logic [VW-1:0] avd;
      bit            pop_m, push_m, set_ovf, set_mis;
      hd_q.push_front(row_psum);
      hv_q.push_front(row_valid);
      if (hv_q.size() > R) begin
        void'(hd_q.pop_back());
        void'(hv_q.pop_back());
      end
      av = '0; avd = '0;
      for (int r = 0; r < R; r++) begin
        int k;
        k = R - 1 - r;
        if (k < hv_q.size()) begin
          av[r] = hv_q[k][r];
          avd[r*W +: W] = hd_q[k][r*W +: W];
        end
      end
      pop_m = (occ > 0) && out_ready;
      push_m = 0; set_ovf = 0; set_mis = 0;
      if (av == '1) begin
        if (occ < D || pop_m) begin
          exp_q.push_back(avd);
          push_m = 1;
        end else set_ovf = 1;
      end else if (av != '0) set_mis = 1;
      occ = occ + int'(push_m) - int'(pop_m);
      if (pop_m) exp_cnt = exp_cnt + 16'd1;
      if (set_ovf) exp_ovf = 1'b1; else if (clr_err) exp_ovf = 1'b0;
      if (set_mis) exp_mis = 1'b1; else if (clr_err) exp_mis = 1'b0;
    end
  end

  // ---------------- monitor ----------------
  logic [VW-1:0] pop_log[$];

  always @(negedge clk) begin
    if (!rst) begin
      check("out_valid", VW'(out_valid), VW'(occ > 0));
      check("overflow", VW'(overflow), VW'(exp_ovf));
      check("err_misalign", VW'(err_misalign), VW'(exp_mis));
      check("result_count", VW'(result_count), VW'(exp_cnt));
      if (out_valid && out_ready) begin
        pop_log.push_back(out_data);
        if (exp_q.size() == 0) check("unexpected_pop", VW'(1), VW'(0));
        else check("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  logic [VW-1:0] tl_d [256];
  logic [R-1:0]  tl_v [256];
  logic          tl_r [256];

  task automatic clear_tl();
    for (int t = 0; t < 256; t++) begin
      tl_d[t] = '0; tl_v[t] = '0; tl_r[t] = 1'b0;
    end
  endtask

  task automatic add_vec(input int s, input logic [VW-1:0] v, input int drop);
    for (int r = 0; r < R; r++) begin
      tl_d[s+r][r*W +: W] = v[r*W +: W];
      if (r != drop) tl_v[s+r][r] = 1'b1;
    end
  endtask

  task automatic play(input int n);
    for (int t = 0; t < n; t++) begin
      @(posedge clk); #1;
      row_psum = tl_d[t]; row_valid = tl_v[t]; out_ready = tl_r[t];
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    repeat (n) begin
      @(posedge clk); #1;
      row_valid = '0; row_psum = '0; out_ready = rdy; clr_err = 1'b0;
    end
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1; clr_err = 1'b1; row_valid = '0; out_ready = 1'b0;
    @(posedge clk); #1; clr_err = 1'b0;
  endtask

  function automatic logic [VW-1:0] splat(input logic [W-1:0] x);
    return {R{x}};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected below 200000", $time);
    $fatal(1);
  end

  initial begin
    #22 rst = 1'b0;
    #1;
    check("rst_out_valid", VW'(out_valid), '0);
    check("rst_out_data", out_data, '0);
    check("rst_flags", VW'({overflow, err_misalign}), '0);
    check("rst_count", VW'(result_count), '0);
    idle(4, 1'b0);

    // single vector into empty FIFO
    clear_tl();
    add_vec(0, 64'h0004_0003_0002_0001, -1);
    for (int t = 0; t < 8; t++) tl_r[t] = 1'b1;
    pop_log.delete();
    play(8);
    idle(3, 1'b1);
    check("t1_data", pop_log.size() > 0 ? pop_log[0] : '1, 64'h0004_0003_0002_0001);
    check("t1_count", VW'(result_count), VW'(1));

    // back-to-back overflow
    clear_tl();
    for (int k = 1; k <= 6; k++) add_vec(k - 1, splat(W'(k * 10)), -1);
    play(9);
    idle(2, 1'b0);
    check("t2_overflow", VW'(overflow), VW'(1));
    pop_log.delete();
    idle(8, 1'b1);
    check("t2_drained", VW'(pop_log.size()), VW'(4));
    check("t2_last", pop_log.size() == 4 ? pop_log[3] : '1, splat(16'd40));
    check("t2_count", VW'(result_count), VW'(5));
    pulse_clr();
    idle(1, 1'b0);
    check("t2_clr", VW'(overflow), VW'(0));

    // full FIFO with simultaneous push and pop
    clear_tl();
    for (int k = 1; k <= 4; k++) add_vec(k - 1, splat(W'(k)), -1);
    add_vec(4, splat(16'd99), -1);
    tl_r[7] = 1'b1;
    pop_log.delete();
    play(8);
    idle(8, 1'b1);
    check("t3_overflow", VW'(overflow), VW'(0));
    check("t3_fifth", pop_log.size() == 5 ? pop_log[4] : '1, splat(16'd99));
    check("t3_count", VW'(result_count), VW'(10));

    // misalignment: row 2 missing
    clear_tl();
    add_vec(0, 64'h0044_0033_0022_0011, 2);
    for (int t = 0; t < 6; t++) tl_r[t] = 1'b1;
    play(6);
    idle(2, 1'b1);
    check("t4_err", VW'(err_misalign), VW'(1));
    check("t4_count", VW'(result_count), VW'(10));
    pulse_clr();
    idle(1, 1'b1);
    check("t4_clr", VW'(err_misalign), VW'(0));

    // signed data passes bit-exact
    clear_tl();
    add_vec(0, {16'hFFFF, 16'h8000, 16'h7FFF, 16'hFFFD}, -1);
    for (int t = 0; t < 8; t++) tl_r[t] = 1'b1;
    pop_log.delete();
    play(8);
    idle(2, 1'b1);
    check("t5_signed", pop_log.size() > 0 ? pop_log[0] : '0, 64'hFFFF_8000_7FFF_FFFD);

    // randomized stream with random back-pressure and occasional misalignment
    clear_tl();
    begin
      int s;
      s = 0;
      for (int k = 0; k < 40; k++) begin
        logic [VW-1:0] v;
        int drop;
        v = {$urandom(), $urandom()};
        drop = ($urandom_range(0, 7) == 0) ? $urandom_range(0, R - 1) : -1;
        add_vec(s, v, drop);
        s += $urandom_range(1, 3);
      end
      for (int t = 0; t < s + R; t++) tl_r[t] = $urandom_range(0, 1);
      play(s + R);
    end
    idle(10, 1'b1);
    check("rand_drained", VW'(exp_q.size()), VW'(0));
    pulse_clr();
    idle(2, 1'b1);

    // asynchronous reset mid-operation
    clear_tl();
    add_vec(0, splat(16'h0A0A), -1);
    add_vec(1, splat(16'h0B0B), -1);
    add_vec(2, splat(16'h0C0C), -1);
    play(5);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", VW'(out_valid), '0);
    check("mid_rst_flags", VW'({overflow, err_misalign}), '0);
    check("mid_rst_count", VW'(result_count), '0);
    row_valid = '0; row_psum = '0;
    @(posedge clk); #2;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      idle(1, 1'b1);
      check("post_rst_valid", VW'(out_valid), '0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
